// File: rtl/dense_output_writer_if.sv
// dense_output_writer_if: accumulator result stream in, tensor RAM write port out
interface dense_output_writer_if #(
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 8,
  parameter int ADDR_W = 8,
  parameter int CH_W   = 6
);
  logic              acc_valid;
  logic [ACC_W-1:0]  acc_data;
  logic [CH_W-1:0]   acc_channel;
  logic              layer_complete;
  logic              tensor_ram_we;
  logic [ADDR_W-1:0] tensor_ram_waddr;
  logic [OUT_W-1:0]  tensor_ram_din;
  modport master (
    output acc_valid, acc_data, acc_channel, layer_complete,
    input  tensor_ram_we, tensor_ram_waddr, tensor_ram_din
  );
  modport slave (
    input  acc_valid, acc_data, acc_channel, layer_complete,
    output tensor_ram_we, tensor_ram_waddr, tensor_ram_din
  );
endinterface

// File: rtl/dense_output_writer.sv
// dense_output_writer: requantizes int32 accumulators to int8 and writes them to tensor RAM (optional DENSE_OUTPUT_RELU_EN)
module dense_output_writer #(
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 8,
  parameter int ADDR_W = 8,
  parameter int CH_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       quant_mult,
  input  logic [4:0]        quant_shift,
  input  logic [7:0]        out_zero_point,
  input  logic [ADDR_W-1:0] out_base_addr,
`ifdef DENSE_OUTPUT_RELU_EN
  input  logic              relu_en,
`endif
  dense_output_writer_if.slave bus,
  output logic [CH_W:0]     write_count,
  output logic              busy,
  output logic              done,
  output logic              stray_valid
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] mult_q, mult_d;
  logic [4:0] shift_q, shift_d;
  logic [7:0] zp_q, zp_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic relu_q, relu_d, relu_in;
  logic v1_q, v1_d, v2_q, v2_d, we_q, we_d;
  logic signed [63:0] prod_q, prod_d;
  logic signed [31:0] hi_q, hi_d;
  logic [CH_W-1:0] ch1_q, ch1_d, ch2_q, ch2_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [OUT_W-1:0] din_q, din_d;
  logic [CH_W:0] cnt_q, cnt_d;
  logic stray_q, stray_d;
  logic start_ok, acc_ok, drained;
  logic signed [63:0] rnd, sh;
  logic signed [33:0] half, r, v, zp_ext, lo;
`ifdef DENSE_OUTPUT_RELU_EN
  assign relu_in = relu_en;
`else
  assign relu_in = 1'b0;
`endif
  // control: state transitions, config latch, counters and the sticky stray flag
  always_comb begin
    start_ok = start && state_q == IDLE;
    acc_ok   = bus.acc_valid && (state_q == RUN || state_q == DRAIN);
    drained  = !v1_q && !v2_q && !bus.acc_valid;
    state_d  = state_q == IDLE  ? (start ? RUN : IDLE) :
               state_q == RUN   ? (bus.layer_complete ? (drained ? DONE : DRAIN) : RUN) :
               state_q == DRAIN ? (drained ? DONE : DRAIN) : IDLE;
    mult_d   = start_ok ? quant_mult : mult_q;
    shift_d  = start_ok ? quant_shift : shift_q;
    zp_d     = start_ok ? out_zero_point : zp_q;
    base_d   = start_ok ? out_base_addr : base_q;
    relu_d   = start_ok ? relu_in : relu_q;
    cnt_d    = start_ok ? '0 : cnt_q + (CH_W+1)'(v2_q);
    stray_d  = start_ok ? 1'b0 :
               stray_q | (bus.acc_valid && (state_q == IDLE || state_q == DONE));
  end
  // datapath: Q31 multiply, rounding high-half with saturation, rounding shift + zero point + clamp
  always_comb begin
    v1_d    = acc_ok;
    ch1_d   = bus.acc_channel;
    prod_d  = $signed(bus.acc_data) * $signed(mult_q);
    rnd     = prod_q + 64'sd1073741824;
    sh      = rnd >>> 31;
    v2_d    = v1_q;
    ch2_d   = ch1_q;
    hi_d    = sh > 64'sh7FFFFFFF ? 32'sh7FFFFFFF :
              sh < -64'sh80000000 ? 32'sh80000000 : sh[31:0];
    half    = (34'sd1 <<< shift_q) >>> 1;
    r       = ($signed({{2{hi_q[31]}}, hi_q}) + half) >>> shift_q;
    zp_ext  = $signed({{26{zp_q[7]}}, zp_q});
    v       = r + zp_ext;
    lo      = relu_q ? zp_ext : -34'sd128;
    we_d    = v2_q;
    waddr_d = base_q + ADDR_W'(ch2_q);
    din_d   = v > 34'sd127 ? 8'h7F : v < lo ? lo[7:0] : v[7:0];
  end
  // state, config and pipeline registers; async reset discards anything in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mult_q  <= '0;
      shift_q <= '0;
      zp_q    <= '0;
      base_q  <= '0;
      relu_q  <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      we_q    <= 1'b0;
      prod_q  <= '0;
      hi_q    <= '0;
      ch1_q   <= '0;
      ch2_q   <= '0;
      waddr_q <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mult_q  <= mult_d;
      shift_q <= shift_d;
      zp_q    <= zp_d;
      base_q  <= base_d;
      relu_q  <= relu_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      we_q    <= we_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      ch1_q   <= ch1_d;
      ch2_q   <= ch2_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      stray_q <= stray_d;
    end
  end
  assign bus.tensor_ram_we    = we_q;
  assign bus.tensor_ram_waddr = waddr_q;
  assign bus.tensor_ram_din   = din_q;
  assign write_count          = cnt_q;
  assign busy                 = state_q != IDLE;
  assign done                 = state_q == DONE;
  assign stray_valid          = stray_q;
endmodule

// File: tb/tb_dense_output_writer.sv
// tb_dense_output_writer: table-driven requantize/write vectors plus multi-cycle corner sequences
module tb_dense_output_writer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [31:0] quant_mult = '0;
  logic [4:0] quant_shift = '0;
  logic [7:0] out_zero_point = '0;
  logic [7:0] out_base_addr = '0;
  logic relu = 1'b0;
  logic [6:0] write_count;
  logic busy, done, stray_valid;
  int tests = 0;
  int fails = 0;
  dense_output_writer_if bus();
  dense_output_writer dut (
    .clk(clk), .reset(reset), .start(start), .quant_mult(quant_mult),
    .quant_shift(quant_shift), .out_zero_point(out_zero_point), .out_base_addr(out_base_addr),
`ifdef DENSE_OUTPUT_RELU_EN
    .relu_en(relu),
`endif
    .bus(bus), .write_count(write_count), .busy(busy), .done(done), .stray_valid(stray_valid)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] mult;
    logic [4:0]  shift;
    logic [7:0]  zp;
    logic [7:0]  base;
    logic [31:0] acc;
    logic [5:0]  ch;
    logic        relu;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_din;
  } vec_t;
  vec_t vecs [7];
  int n_vec;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic begin_layer(input logic [31:0] m, input logic [4:0] s, input logic [7:0] z,
                             input logic [7:0] b, input logic rl);
    quant_mult = m;
    quant_shift = s;
    out_zero_point = z;
    out_base_addr = b;
    relu = rl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    bus.acc_valid = 1'b0;
    bus.acc_data = '0;
    bus.acc_channel = '0;
    bus.layer_complete = 1'b0;
    vecs[0] = '{32'h40000000, 5'd0, 8'h00, 8'h10, 32'd100, 6'd3, 1'b0, 8'h13, 8'h32};
    vecs[1] = '{32'h7FFFFFFF, 5'd0, 8'h00, 8'h00, 32'd1000000, 6'd0, 1'b0, 8'h00, 8'h7F};
    vecs[2] = '{32'h7FFFFFFF, 5'd0, 8'h00, 8'h00, -32'sd1000000, 6'd5, 1'b0, 8'h05, 8'h80};
    vecs[3] = '{32'h40000000, 5'd2, 8'hFB, 8'h40, 32'd13, 6'd7, 1'b0, 8'h47, 8'hFD};
    vecs[4] = '{32'h40000000, 5'd0, 8'h00, 8'hFE, 32'd100, 6'd3, 1'b0, 8'h01, 8'h32};
    vecs[5] = '{32'h40000000, 5'd1, 8'h03, 8'h80, -32'sd7, 6'd63, 1'b0, 8'hBF, 8'h02};
    vecs[6] = '{32'h40000000, 5'd0, 8'h0A, 8'h00, -32'sd500, 6'd1, 1'b1, 8'h01, 8'h0A};
`ifdef DENSE_OUTPUT_RELU_EN
    n_vec = 7;
`else
    n_vec = 6;
`endif
    tick();
    tick();
    check("rst_we", bus.tensor_ram_we, 0);
    check("rst_waddr", bus.tensor_ram_waddr, 0);
    check("rst_din", bus.tensor_ram_din, 0);
    check("rst_count", write_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stray", stray_valid, 0);
    reset = 1'b1;
    tick();
    // stray valid while IDLE: dropped, flag set, cleared by start
    bus.acc_valid = 1'b1;
    bus.acc_data = 32'd100;
    bus.acc_channel = 6'd2;
    tick();
    bus.acc_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stray_we_c%0d", k), bus.tensor_ram_we, 0);
      tick();
    end
    check("stray_set", stray_valid, 1);
    check("stray_idle", busy, 0);
    begin_layer(32'h40000000, 5'd0, 8'h00, 8'h00, 1'b0);
    check("stray_cleared", stray_valid, 0);
    check("start_busy", busy, 1);
    bus.layer_complete = 1'b1;
    tick();
    bus.layer_complete = 1'b0;
    check("empty_done", done, 1);
    check("empty_count", write_count, 0);
    tick();
    check("empty_idle", busy, 0);
    // table-driven single-result layers
    for (int i = 0; i < n_vec; i++) begin
      begin_layer(vecs[i].mult, vecs[i].shift, vecs[i].zp, vecs[i].base, vecs[i].relu);
      bus.acc_valid = 1'b1;
      bus.acc_data = vecs[i].acc;
      bus.acc_channel = vecs[i].ch;
      tick();
      bus.acc_valid = 1'b0;
      check($sformatf("v%0d_we_t1", i), bus.tensor_ram_we, 0);
      tick();
      check($sformatf("v%0d_we_t2", i), bus.tensor_ram_we, 0);
      tick();
      check($sformatf("v%0d_we_t3", i), bus.tensor_ram_we, 1);
      check($sformatf("v%0d_waddr", i), bus.tensor_ram_waddr, {56'd0, vecs[i].exp_addr});
      check($sformatf("v%0d_din", i), bus.tensor_ram_din, {56'd0, vecs[i].exp_din});
      check($sformatf("v%0d_count", i), write_count, 1);
      bus.layer_complete = 1'b1;
      tick();
      bus.layer_complete = 1'b0;
      check($sformatf("v%0d_we_off", i), bus.tensor_ram_we, 0);
      check($sformatf("v%0d_done", i), done, 1);
      tick();
      check($sformatf("v%0d_done_off", i), done, 0);
      check($sformatf("v%0d_idle", i), busy, 0);
    end
    // back-to-back: four valids, then complete; writes on cycles 2..5, done on 6
    begin_layer(32'h40000000, 5'd0, 8'h00, 8'h20, 1'b0);
    for (int n = 0; n < 8; n++) begin
      bus.acc_valid = n < 4;
      bus.acc_channel = 6'(n);
      bus.acc_data = 32'(10 * (n + 1));
      bus.layer_complete = n >= 4;
      tick();
      check($sformatf("b2b_we_c%0d", n), bus.tensor_ram_we, (n >= 2 && n <= 5) ? 1 : 0);
      check($sformatf("b2b_done_c%0d", n), done, n == 6 ? 1 : 0);
      if (n >= 2 && n <= 5) begin
        check($sformatf("b2b_waddr_c%0d", n), bus.tensor_ram_waddr, 64'(8'h20 + n - 2));
        check($sformatf("b2b_din_c%0d", n), bus.tensor_ram_din, 64'(5 * (n - 1)));
        check($sformatf("b2b_count_c%0d", n), write_count, 64'(n - 1));
      end
    end
    bus.acc_valid = 1'b0;
    bus.layer_complete = 1'b0;
    check("b2b_final_count", write_count, 4);
    check("b2b_idle", busy, 0);
    // reset with two results in flight
    begin_layer(32'h40000000, 5'd0, 8'h00, 8'h10, 1'b0);
    bus.acc_valid = 1'b1;
    bus.acc_data = 32'd100;
    bus.acc_channel = 6'd0;
    tick();
    bus.acc_channel = 6'd1;
    tick();
    bus.acc_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_rst_we", bus.tensor_ram_we, 0);
    check("mid_rst_waddr", bus.tensor_ram_waddr, 0);
    check("mid_rst_din", bus.tensor_ram_din, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", write_count, 0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("post_rst_we_c%0d", k), bus.tensor_ram_we, 0);
      check($sformatf("post_rst_busy_c%0d", k), busy, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
